// File: rtl/ddr_host_req_queue_if.sv
// ddr_host_req_queue_if
//   Host-side request bus and controller-side command bus of the DDR host
//   request queue, bundled as one interface.
//
//   Host side : request, phy_addr, wr_data  -> queue ; host_ready <- queue
//   Cmd side  : cmd_valid, cmd_req, cmd_addr, cmd_wdata -> controller ;
//               cmd_rdy <- controller
//
//   Handshake rules (both sides):
//     - A host request (code READ=1 or WRITE=2) is taken at a posedge only if
//       host_ready is 1 in that cycle; otherwise it is dropped, not stalled.
//     - A command transfers at a posedge where cmd_valid && cmd_rdy. While
//       cmd_valid is 1 the cmd_* fields are stable until that transfer;
//       cmd_rdy has no effect while cmd_valid is 0.
//
//   modport slave  : the queue itself.
//   modport master : the environment (host driver plus controller).
interface ddr_host_req_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [2:0]        request;
  logic [ADDR_W-1:0] phy_addr;
  logic [DATA_W-1:0] wr_data;
  logic              host_ready;
  logic              cmd_valid;
  logic [2:0]        cmd_req;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              cmd_rdy;

  modport slave (
    input  request, phy_addr, wr_data, cmd_rdy,
    output host_ready, cmd_valid, cmd_req, cmd_addr, cmd_wdata
  );

  modport master (
    output request, phy_addr, wr_data, cmd_rdy,
    input  host_ready, cmd_valid, cmd_req, cmd_addr, cmd_wdata
  );
endinterface

// File: rtl/ddr_host_req_queue.sv
// ddr_host_req_queue
//   Front-end FIFO between the host driver and the DDR4 controller command
//   path. Buffers READ/WRITE requests and presents the head first-word-
//   fall-through. Owns the live mode-register timing configuration; an MRS
//   update is held in a shadow copy and applied only after the queue is
//   empty and the controller is idle.
//
// Ports
//   CK_t, RESET_n      clock, synchronous active-low reset
//   host               request/command bus (ddr_host_req_queue_if.slave)
//   mrs_update         one-cycle request for a configuration change
//   CL/AL/BL/CWL/RD_PRE/WR_PRE   new timing values, sampled with mrs_update
//   busy               controller has a transaction in flight
//   cfg_*              active configuration
//   cfg_update         one-cycle pulse in the cycle the new config appears
//   count              queue occupancy
//   drop_err           sticky: a valid request arrived while host_ready=0
//   state_dbg          FSM state (0 RUN, 1 DRAIN, 2 APPLY)
module ddr_host_req_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                     CK_t,
  input  logic                     RESET_n,
  ddr_host_req_queue_if.slave      host,
  input  logic                     mrs_update,
  input  logic [2:0]               CL,
  input  logic [2:0]               BL,
  input  logic [2:0]               CWL,
  input  logic [1:0]               AL,
  input  logic                     RD_PRE,
  input  logic                     WR_PRE,
  input  logic                     busy,
  output logic [2:0]               cfg_CL,
  output logic [2:0]               cfg_BL,
  output logic [2:0]               cfg_CWL,
  output logic [1:0]               cfg_AL,
  output logic                     cfg_RD_PRE,
  output logic                     cfg_WR_PRE,
  output logic                     cfg_update,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop_err,
  output logic [1:0]               state_dbg
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [2:0] REQ_RD = 3'd1;
  localparam logic [2:0] REQ_WR = 3'd2;

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, APPLY = 2'd2} state_t;
  state_t state;

  // Configuration packed as {CL, AL, BL, CWL, RD_PRE, WR_PRE}.
  logic [12:0] cfg_q, shadow_q, mrs_in;
  assign mrs_in = {CL, AL, BL, CWL, RD_PRE, WR_PRE};
  assign {cfg_CL, cfg_AL, cfg_BL, cfg_CWL, cfg_RD_PRE, cfg_WR_PRE} = cfg_q;
  assign state_dbg = state;

  // FIFO storage and head registers
  logic [2:0]        mem_req  [DEPTH];
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_nxt;
  logic [2:0]        head_req;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              req_valid, enq, deq;

  assign req_valid       = (host.request == REQ_RD) || (host.request == REQ_WR);
  assign host.host_ready = (state == RUN) && (count < FULL);
  assign host.cmd_valid  = (count != '0);
  assign enq             = req_valid && host.host_ready;
  assign deq             = host.cmd_valid && host.cmd_rdy;
  assign rd_nxt          = rd_ptr + 1'b1;
  assign host.cmd_req    = head_req;
  assign host.cmd_addr   = head_addr;
  assign host.cmd_wdata  = head_data;

  always_ff @(posedge CK_t) begin
    if (RESET_n && enq) begin
      mem_req[wr_ptr]  <= host.request;
      mem_addr[wr_ptr] <= host.phy_addr;
      mem_data[wr_ptr] <= host.wr_data;
    end
  end

  // The head is kept in registers so the outputs read 0 after reset and hold
  // the last dispatched entry while the queue is empty.
  always_ff @(posedge CK_t) begin
    if (!RESET_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      head_req  <= '0;
      head_addr <= '0;
      head_data <= '0;
      drop_err  <= 1'b0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_nxt;
      case ({enq, deq})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: ;
      endcase
      if (deq && (count > ONE)) begin
        // Next-oldest entry is already in storage.
        head_req  <= mem_req[rd_nxt];
        head_addr <= mem_addr[rd_nxt];
        head_data <= mem_data[rd_nxt];
      end else if (enq && ((count == '0) || (deq && (count == ONE)))) begin
        // Incoming request becomes the head directly.
        head_req  <= host.request;
        head_addr <= host.phy_addr;
        head_data <= host.wr_data;
      end
      if (req_valid && !host.host_ready) drop_err <= 1'b1;
    end
  end

  // MRS sequencer. cfg_update is registered so it is high exactly in the
  // APPLY cycle, together with the freshly loaded configuration.
  always_ff @(posedge CK_t) begin
    if (!RESET_n) begin
      state      <= RUN;
      cfg_q      <= '0;
      shadow_q   <= '0;
      cfg_update <= 1'b0;
    end else begin
      cfg_update <= 1'b0;
      if (mrs_update) shadow_q <= mrs_in;
      case (state)
        RUN:   if (mrs_update) state <= DRAIN;
        DRAIN: begin
          if ((count == '0) && !busy) begin
            state      <= APPLY;
            // A pulse arriving on the exit edge still wins over the shadow.
            cfg_q      <= mrs_update ? mrs_in : shadow_q;
            cfg_update <= 1'b1;
          end
        end
        APPLY:   state <= mrs_update ? DRAIN : RUN;
        default: state <= RUN;
      endcase
    end
  end
endmodule
